// File: rtl/interleaver_pkg.sv
// Shared constants and types for the convolutional interleaver controller.
// Holds the default geometry (branch count, packet length, byte width),
// the per-branch delay unit, the MPEG-TS sync byte value and the FSM state type.
package interleaver_pkg;

  localparam int NUM_BRANCH = 12;
  localparam int PKT_LEN    = 204;
  localparam int WIDTH      = 8;
  localparam int DEPTH_UNIT = 17;

  localparam logic [7:0] SYNC_BYTE = 8'h47;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/interleaver_ctrl_onehot.sv
// One-hot decoder with enable.
// Ports:
//   idx    - binary index to decode
//   en     - when low, the output is all zeros
//   onehot - bit idx set when en is high; indices >= N decode to zero
module interleaver_ctrl_onehot #(
  parameter int N  = 12,
  parameter int IW = 4
) (
  input  logic [IW-1:0] idx,
  input  logic          en,
  output logic [N-1:0]  onehot
);

  always_comb begin
    // NOTE: every output bit is assigned on every pass, so no latch is inferred.
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = en && (idx == IW'(i));
    end
  end

endmodule

// File: rtl/interleaver_ctrl.sv
// Convolutional interleaver controller.
// Commutates accepted bytes round-robin over NUM_BRANCH external, enable-gated
// delay lines (branch j is j*DEPTH_UNIT bytes deep) and re-collects the delayed
// bytes into a single output stream. Packet alignment is checked against
// sync_in on every byte; a mismatch drops the byte, pulses sync_err and
// returns to IDLE until the next sync-marked byte.
// Ports:
//   clk, reset           - single clock, synchronous active-high reset
//   in_valid/in_ready    - input handshake; in_data byte, sync_in marks byte 0
//   br_data, br_en       - byte and one-hot shift enable to the delay lines
//   br_q                 - last stage of each delay line (branch 0 slice unused)
//   out_valid/out_ready  - output handshake; out_data interleaved byte
//   branch_idx           - branch that receives the next accepted byte
//   sync_err             - one-cycle pulse on packet alignment loss
module interleaver_ctrl #(
  parameter int NUM_BRANCH = interleaver_pkg::NUM_BRANCH,
  parameter int PKT_LEN    = interleaver_pkg::PKT_LEN,
  parameter int WIDTH      = interleaver_pkg::WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        sync_in,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            br_data,
  output logic [NUM_BRANCH-1:0]       br_en,
  input  logic [NUM_BRANCH*WIDTH-1:0] br_q,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        out_ready,
  output logic [3:0]                  branch_idx,
  output logic                        sync_err
);

  import interleaver_pkg::*;

  localparam int CNT_W = $clog2(PKT_LEN);

  state_e             state_q, state_d;
  logic [3:0]         branch_idx_q, branch_idx_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic               a_valid_q, a_valid_d;
  logic [WIDTH-1:0]   a_data_q, a_data_d;
  logic [3:0]         a_idx_q, a_idx_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               sync_err_q, sync_err_d;

  logic               a_adv, a_ready, xfer, sync_ok, take, bad, shift_en;
  logic [WIDTH-1:0]   tap;
  logic               unused_br0;

  // Branch 0 has no delay line; its byte bypasses straight from stage A.
  assign unused_br0 = ^br_q[WIDTH-1:0];

  // Stage A moves on when stage B is empty or being drained this cycle.
  assign a_adv   = a_valid_q & (~out_valid_q | out_ready);
  assign a_ready = ~a_valid_q | a_adv;
  assign xfer    = in_valid & in_ready;
  assign sync_ok = ((byte_cnt_q == '0) == sync_in);

  // State register (holds every flop of the block).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      branch_idx_q <= '0;
      byte_cnt_q   <= '0;
      a_valid_q    <= 1'b0;
      a_data_q     <= '0;
      a_idx_q      <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      sync_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      branch_idx_q <= branch_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      a_valid_q    <= a_valid_d;
      a_data_q     <= a_data_d;
      a_idx_q      <= a_idx_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      sync_err_q   <= sync_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (xfer && sync_in) state_d = ST_RUN;
      ST_RUN:  if (bad)             state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Output / transfer classification.
  always_comb begin
    // Stage A must be free to take a byte. In IDLE this is high except while a
    // byte left over from before an alignment loss is still stalled in stage A.
    in_ready = a_ready;
    take     = 1'b0;
    bad      = 1'b0;
    if (state_q == ST_IDLE) begin
      take = xfer & sync_in;
    end else begin
      take = xfer & sync_ok;
      bad  = xfer & ~sync_ok;
    end
  end

  // Counters and pipeline stages.
  always_comb begin
    branch_idx_d = branch_idx_q;
    byte_cnt_d   = byte_cnt_q;
    if (bad) begin
      branch_idx_d = '0;
      byte_cnt_d   = '0;
    end else if (take) begin
      branch_idx_d = (branch_idx_q == 4'(NUM_BRANCH - 1)) ? '0 : branch_idx_q + 4'd1;
      byte_cnt_d   = (byte_cnt_q == CNT_W'(PKT_LEN - 1)) ? '0 : byte_cnt_q + CNT_W'(1);
    end

    a_valid_d = a_valid_q;
    a_data_d  = a_data_q;
    a_idx_d   = a_idx_q;
    if (take) begin
      a_valid_d = 1'b1;
      a_data_d  = in_data;
      a_idx_d   = branch_idx_q;
    end else if (a_adv) begin
      a_valid_d = 1'b0;
    end

    // Branch output as it is before this edge's shift.
    tap = a_data_q;
    for (int j = 1; j < NUM_BRANCH; j++) begin
      if (a_idx_q == 4'(j)) tap = br_q[j*WIDTH +: WIDTH];
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (a_adv) begin
      out_valid_d = 1'b1;
      out_data_d  = tap;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    sync_err_d = bad;
  end

  // Shifting is tied to a_adv, so a stalled byte never shifts twice; reset
  // suppresses the shift of a byte that is being discarded.
  assign shift_en = a_adv & ~reset;

  interleaver_ctrl_onehot #(
    .N  (NUM_BRANCH),
    .IW (4)
  ) u_onehot (
    .idx    (a_idx_q),
    .en     (shift_en),
    .onehot (br_en)
  );

  assign br_data    = a_data_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign branch_idx = branch_idx_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_interleaver_ctrl.sv
// Self-checking bench for interleaver_ctrl: directed scenarios followed by
// randomized traffic, compared against a packet/branch-level reference model.
module tb_interleaver_ctrl;

  import interleaver_pkg::*;

  localparam int NB = NUM_BRANCH;
  localparam int W  = WIDTH;
  localparam int PL = PKT_LEN;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, sync_in, in_ready;
  logic [W-1:0]    in_data, br_data, out_data;
  logic [NB-1:0]   br_en;
  logic [NB*W-1:0] br_q;
  logic            out_valid, out_ready, sync_err;
  logic [3:0]      branch_idx;

  always #5 clk = ~clk;

  interleaver_ctrl #(
    .NUM_BRANCH (NB),
    .PKT_LEN    (PL),
    .WIDTH      (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .sync_in    (sync_in),
    .in_ready   (in_ready),
    .br_data    (br_data),
    .br_en      (br_en),
    .br_q       (br_q),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .branch_idx (branch_idx),
    .sync_err   (sync_err)
  );

  // External enable-gated delay lines as circular buffers.
  logic [W-1:0] line [NB][PL];
  int           ptr  [NB];

  always_comb begin
    br_q = '0;
    for (int j = 1; j < NB; j++) br_q[j*W +: W] = line[j][ptr[j]];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: packet alignment rules plus a per-branch FIFO of the
  // bytes written to that branch, from which the delayed byte is taken.
  bit           m_run;
  int           m_cnt, m_idx;
  bit           m_err;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] hist  [NB][$];

  task automatic clear_model();
    m_run = 0; m_cnt = 0; m_idx = 0; m_err = 0;
    exp_q.delete();
    for (int j = 0; j < NB; j++) begin
      hist[j].delete();
      ptr[j] = 0;
      for (int k = 0; k < PL; k++) line[j][k] = '0;
    end
  endtask

  task automatic model_byte(input int j, input logic [W-1:0] d);
    logic [W-1:0] e;
    if (j == 0) begin
      e = d;
    end else begin
      hist[j].push_back(d);
      if (hist[j].size() > j * DEPTH_UNIT) e = hist[j].pop_front();
      else e = '0;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit v, input bit s, input logic [W-1:0] d, input bit r);
    in_valid  = v;
    sync_in   = s;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  // One clock: check outputs, update the model, advance the edge, shift lines.
  task automatic step();
    bit            bad;
    logic [NB-1:0] en_s;
    logic [W-1:0]  d_s;
    bad = 0;
    check("branch_idx", branch_idx, m_idx);
    check("sync_err", sync_err, m_err);
    if (out_valid) begin
      check("out_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        check("out_data", out_data, exp_q[0]);
        if (out_ready && !reset) void'(exp_q.pop_front());
      end
    end
    if (in_valid && in_ready && !reset) begin
      if (!m_run) begin
        if (sync_in) begin
          model_byte(0, in_data);
          m_run = 1; m_cnt = 1; m_idx = 1;
        end
      end else if ((m_cnt == 0) != sync_in) begin
        bad = 1; m_run = 0; m_cnt = 0; m_idx = 0;
      end else begin
        model_byte(m_idx, in_data);
        m_cnt = (m_cnt + 1) % PL;
        m_idx = (m_idx + 1) % NB;
      end
    end
    m_err = bad;
    en_s  = br_en;
    d_s   = br_data;
    @(posedge clk);
    #1;
    if (reset) begin
      clear_model();
    end else begin
      for (int j = 1; j < NB; j++) begin
        if (en_s[j]) begin
          line[j][ptr[j]] = d_s;
          ptr[j] = (ptr[j] + 1) % (j * DEPTH_UNIT);
        end
      end
    end
  endtask

  task automatic send_rand(input bit r);
    drive(1'b1, (m_cnt == 0), W'($urandom), r);
    step();
  endtask

  logic [NB-1:0] one = 1;
  int            y_idx;

  initial begin
    clear_model();
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b1);

    // Reset state.
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_br_en", br_en, 0);
    check("rst_br_data", br_data, 0);
    check("rst_branch_idx", branch_idx, 0);
    check("rst_sync_err", sync_err, 0);

    // Sync byte then 0x01..0x0B: one-hot enable walks across the branches.
    for (int k = 0; k < NB; k++) begin
      drive(1'b1, (k == 0), (k == 0) ? 8'h47 : W'(k), 1'b1);
      if (k >= 1) check("br_en_seq", br_en, one << (k - 1));
      if (k == 2) begin
        check("first_out_valid", out_valid, 1);
        check("first_out_data", out_data, 8'h47);
      end
      step();
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    check("br_en_seq", br_en, one << (NB - 1));
    step();

    // Rest of the packet, then the next packet's first byte without sync_in.
    while (m_cnt != 0) send_rand(1'b1);
    drive(1'b1, 1'b0, 8'hC3, 1'b1);
    step();
    drive(1'b0, 1'b0, '0, 1'b1);
    check("err_pulse", sync_err, 1);
    check("err_branch_idx", branch_idx, 0);
    check("err_br_en", br_en, 0);
    step();
    for (int k = 0; k < 30; k++) begin
      drive(1'b1, 1'b0, W'($urandom), 1'b1);
      check("idle_br_en", br_en, 0);
      step();
    end

    // Continuous aligned packets through the full delay span.
    for (int k = 0; k < 3 * PL; k++) send_rand(1'b1);
    repeat (4) begin drive(1'b0, 1'b0, '0, 1'b1); step(); end

    // Backpressure with stage A occupied.
    drive(1'b1, 1'b1, 8'hA5, 1'b0);
    step();
    y_idx = m_idx;
    drive(1'b1, 1'b0, 8'h5A, 1'b0);
    step();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 8'hFF, 1'b0);
      check("stall_in_ready", in_ready, 0);
      check("stall_br_en", br_en, 0);
      check("stall_out_valid", out_valid, 1);
      step();
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    check("release_br_en", br_en, one << y_idx);
    step();
    drive(1'b0, 1'b0, '0, 1'b1);
    check("release_br_en_off", br_en, 0);
    step();
    repeat (3) begin drive(1'b0, 1'b0, '0, 1'b1); step(); end

    // Reset at byte 100 of a packet.
    while (m_cnt != 0) send_rand(1'b1);
    for (int k = 0; k < 100; k++) send_rand(1'b1);
    reset = 1'b1;
    drive(1'b1, 1'b0, 8'h11, 1'b1);
    check("rst_mid_br_en", br_en, 0);
    step();
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b1);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_br_en_after", br_en, 0);
    check("rst_mid_branch_idx", branch_idx, 0);
    check("rst_mid_in_ready", in_ready, 1);
    step();

    // Randomized traffic with backpressure and occasional alignment errors.
    for (int c = 0; c < 6000; c++) begin
      bit v, r, s;
      v = ($urandom_range(0, 9) < 8);
      r = ($urandom_range(0, 9) < 7);
      if (m_run) s = (m_cnt == 0) ^ ($urandom_range(0, 299) == 0);
      else s = ($urandom_range(0, 3) == 0);
      drive(v, s, W'($urandom), r);
      step();
    end
    repeat (10) begin drive(1'b0, 1'b0, '0, 1'b1); step(); end
    check("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
